// File: rtl/lockstep_recovery_ctrl.sv
// lockstep_recovery_ctrl
//   N-way lockstep checker and recovery controller for replicated zeroriscy
//   cores. Every cycle the per-core register-file write tuples
//   {we, waddr, wdata} are compared and majority-voted. On a correctable
//   mismatch all cores are halted, the voted register value and the saved PC
//   are written back into the faulty cores over the debug port, and the cores
//   are resumed. A mismatch with no majority, or a halt that never completes,
//   ends in a sticky FATAL state that only rst_i clears.
//
// Optional feature: define LOCKSTEP_STATS_EN to add fault_cnt_o, which holds
//   per-core saturating 8-bit counts of correctable events blamed on each core.
//
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   enable_i          checking enable; mismatches ignored when low
//   rf_we_i/waddr_i/wdata_i  per-core regfile write ports, core k packed at slot k
//   pc_i              core-0 fetch address, saved when a mismatch is detected
//   dbg_halt_o/resume_o      one-cycle halt/resume pulses to all cores
//   dbg_halted_i      per-core halted status
//   dbg_req_o/gnt_i   per-core debug write handshake
//   dbg_we_o/addr_o/wdata_o  shared debug write command
//   faulty_mask_o     cores outvoted in the last correctable event
//   fault_o           recovery in progress
//   fatal_o           sticky uncorrectable error
//   recover_cnt_o     saturating count of completed recoveries
module lockstep_recovery_ctrl #(
  parameter int NUM_CORES    = 3,
  parameter int DATA_W       = 32,
  parameter int HALT_TIMEOUT = 64,
  parameter int CNT_W        = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          enable_i,
  input  logic [NUM_CORES-1:0]          rf_we_i,
  input  logic [NUM_CORES*5-1:0]        rf_waddr_i,
  input  logic [NUM_CORES*DATA_W-1:0]   rf_wdata_i,
  input  logic [DATA_W-1:0]             pc_i,
  output logic                          dbg_halt_o,
  output logic                          dbg_resume_o,
  input  logic [NUM_CORES-1:0]          dbg_halted_i,
  output logic [NUM_CORES-1:0]          dbg_req_o,
  input  logic [NUM_CORES-1:0]          dbg_gnt_i,
  output logic                          dbg_we_o,
  output logic [14:0]                   dbg_addr_o,
  output logic [DATA_W-1:0]             dbg_wdata_o,
  output logic [NUM_CORES-1:0]          faulty_mask_o,
  output logic                          fault_o,
  output logic                          fatal_o,
  output logic [CNT_W-1:0]              recover_cnt_o
`ifdef LOCKSTEP_STATS_EN
  ,
  output logic [NUM_CORES*8-1:0]        fault_cnt_o
`endif
);

  typedef enum logic [2:0] {
    S_RUN, S_HALT, S_WAIT_HALTED, S_WR_REG, S_WR_PC, S_RESUME, S_FATAL
  } state_t;

  localparam int              TO_W    = (HALT_TIMEOUT > 1) ? $clog2(HALT_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(HALT_TIMEOUT - 1);
  localparam logic [3:0]      MAJ_MIN = 4'(NUM_CORES / 2 + 1);

  function automatic logic tuple_eq(input logic we_a, input logic we_b,
                                    input logic [4:0] a_a, input logic [4:0] a_b,
                                    input logic [DATA_W-1:0] d_a, input logic [DATA_W-1:0] d_b);
    return (!we_a && !we_b) || (we_a && we_b && (a_a == a_b) && (d_a == d_b));
  endfunction

  logic                 core_we   [NUM_CORES];
  logic [4:0]           core_addr [NUM_CORES];
  logic [DATA_W-1:0]    core_data [NUM_CORES];
  logic [NUM_CORES-1:0] agree_m   [NUM_CORES];

  always_comb begin
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      core_we[k]   = rf_we_i[k];
      core_addr[k] = rf_waddr_i[5*k +: 5];
      core_data[k] = rf_wdata_i[DATA_W*k +: DATA_W];
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      for (int unsigned j = 0; j < NUM_CORES; j++) begin
        agree_m[i][j] = tuple_eq(core_we[i], core_we[j], core_addr[i], core_addr[j],
                                 core_data[i], core_data[j]);
      end
    end
  end

  // First core whose tuple is shared by a strict majority supplies the vote;
  // any majority is unique, so the choice of "first" is immaterial.
  logic [3:0]           agree_cnt;
  logic                 maj_found;
  logic                 maj_we_c;
  logic [4:0]           maj_addr_c;
  logic [DATA_W-1:0]    maj_data_c;
  logic [NUM_CORES-1:0] maj_mask;
  logic                 all_agree;

  always_comb begin
    agree_cnt  = '0;
    maj_found  = 1'b0;
    maj_we_c   = 1'b0;
    maj_addr_c = '0;
    maj_data_c = '0;
    maj_mask   = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      agree_cnt = '0;
      for (int unsigned j = 0; j < NUM_CORES; j++) begin
        if (agree_m[i][j]) agree_cnt = agree_cnt + 4'd1;
      end
      if (!maj_found && (agree_cnt >= MAJ_MIN)) begin
        maj_found  = 1'b1;
        maj_we_c   = core_we[i];
        maj_addr_c = core_addr[i];
        maj_data_c = core_data[i];
        maj_mask   = ~agree_m[i];
      end
    end
    all_agree = &agree_m[0];
  end

  state_t               state, state_n;
  logic [NUM_CORES-1:0] pending, mask_q;
  logic                 maj_we_q;
  logic [4:0]           maj_addr_q;
  logic [DATA_W-1:0]    maj_data_q, pc_q;
  logic [TO_W-1:0]      to_cnt;
  logic                 fatal_entered;
  logic [CNT_W-1:0]     rcnt;
  logic                 detect, load_req;

  assign detect   = (state == S_RUN) && enable_i && !all_agree;
  assign load_req = ((state_n == S_WR_REG) || (state_n == S_WR_PC)) && (state_n != state);

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_RUN;
    else       state <= state_n;
  end

  always_comb begin
    state_n       = state;
    dbg_halt_o    = 1'b0;
    dbg_resume_o  = 1'b0;
    dbg_req_o     = '0;
    dbg_we_o      = 1'b0;
    dbg_addr_o    = '0;
    dbg_wdata_o   = '0;
    fault_o       = 1'b0;
    fatal_o       = 1'b0;
    case (state)
      S_RUN: begin
        if (detect) state_n = maj_found ? S_HALT : S_FATAL;
      end
      S_HALT: begin
        dbg_halt_o = 1'b1;
        fault_o    = 1'b1;
        state_n    = S_WAIT_HALTED;
      end
      S_WAIT_HALTED: begin
        fault_o = 1'b1;
        if (&dbg_halted_i)          state_n = maj_we_q ? S_WR_REG : S_WR_PC;
        else if (to_cnt == TO_LAST) state_n = S_FATAL;
      end
      S_WR_REG: begin
        fault_o     = 1'b1;
        dbg_req_o   = pending;
        dbg_we_o    = 1'b1;
        dbg_addr_o  = 15'h400 + {8'b0, maj_addr_q, 2'b00};
        dbg_wdata_o = maj_data_q;
        if ((pending & ~dbg_gnt_i) == '0) state_n = S_WR_PC;
      end
      S_WR_PC: begin
        fault_o     = 1'b1;
        dbg_req_o   = pending;
        dbg_we_o    = 1'b1;
        dbg_addr_o  = 15'h2000;
        dbg_wdata_o = pc_q;
        if ((pending & ~dbg_gnt_i) == '0) state_n = S_RESUME;
      end
      S_RESUME: begin
        fault_o      = 1'b1;
        dbg_resume_o = 1'b1;
        state_n      = S_RUN;
      end
      S_FATAL: begin
        fatal_o    = 1'b1;
        dbg_halt_o = !fatal_entered;
      end
      default: state_n = S_RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mask_q        <= '0;
      pending       <= '0;
      maj_we_q      <= 1'b0;
      maj_addr_q    <= '0;
      maj_data_q    <= '0;
      pc_q          <= '0;
      to_cnt        <= '0;
      fatal_entered <= 1'b0;
      rcnt          <= '0;
    end else begin
      if (detect) begin
        maj_we_q   <= maj_we_c;
        maj_addr_q <= maj_addr_c;
        maj_data_q <= maj_data_c;
        pc_q       <= pc_i;
        if (maj_found) mask_q <= maj_mask;
      end
      // Each write phase re-arms every faulty core; a bit clears once granted.
      if (load_req) pending <= mask_q;
      else          pending <= pending & ~dbg_gnt_i;
      to_cnt        <= (state == S_WAIT_HALTED) ? to_cnt + 1'b1 : '0;
      fatal_entered <= (state == S_FATAL);
      if ((state == S_RESUME) && (rcnt != '1)) rcnt <= rcnt + 1'b1;
    end
  end

  assign faulty_mask_o = mask_q;
  assign recover_cnt_o = rcnt;

`ifdef LOCKSTEP_STATS_EN
  logic [7:0] fcnt [NUM_CORES];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned k = 0; k < NUM_CORES; k++) fcnt[k] <= '0;
    end else if (detect && maj_found) begin
      for (int unsigned k = 0; k < NUM_CORES; k++) begin
        if (maj_mask[k] && (fcnt[k] != '1)) fcnt[k] <= fcnt[k] + 8'd1;
      end
    end
  end

  always_comb begin
    fault_cnt_o = '0;
    for (int unsigned k = 0; k < NUM_CORES; k++) fault_cnt_o[8*k +: 8] = fcnt[k];
  end
`endif

endmodule

// File: tb/tb_lockstep_recovery_ctrl.sv
module tb_lockstep_recovery_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // 3-core instance
  logic        rst3, en3;
  logic [2:0]  we3, halted3, gnt3;
  logic [14:0] waddr3;
  logic [95:0] wdata3;
  logic [31:0] pc3;
  logic        halt3, resume3, dwe3, fault3, fatal3;
  logic [2:0]  req3, mask3;
  logic [14:0] addr3;
  logic [31:0] dwd3;
  logic [15:0] rc3;

  // 5-core instance
  logic         rst5, en5;
  logic [4:0]   we5, halted5, gnt5;
  logic [24:0]  waddr5;
  logic [159:0] wdata5;
  logic [31:0]  pc5;
  logic         halt5, resume5, dwe5, fault5, fatal5;
  logic [4:0]   req5, mask5;
  logic [14:0]  addr5;
  logic [31:0]  dwd5;
  logic [15:0]  rc5;
`ifdef LOCKSTEP_STATS_EN
  logic [23:0]  fc3;
  logic [39:0]  fc5;
`endif

  lockstep_recovery_ctrl #(.NUM_CORES(3), .DATA_W(32), .HALT_TIMEOUT(64), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst3), .enable_i(en3), .rf_we_i(we3), .rf_waddr_i(waddr3),
    .rf_wdata_i(wdata3), .pc_i(pc3), .dbg_halt_o(halt3), .dbg_resume_o(resume3),
    .dbg_halted_i(halted3), .dbg_req_o(req3), .dbg_gnt_i(gnt3), .dbg_we_o(dwe3),
    .dbg_addr_o(addr3), .dbg_wdata_o(dwd3), .faulty_mask_o(mask3), .fault_o(fault3),
    .fatal_o(fatal3), .recover_cnt_o(rc3)
`ifdef LOCKSTEP_STATS_EN
    , .fault_cnt_o(fc3)
`endif
  );

  lockstep_recovery_ctrl #(.NUM_CORES(5), .DATA_W(32), .HALT_TIMEOUT(64), .CNT_W(16)) dut5 (
    .clk_i(clk), .rst_i(rst5), .enable_i(en5), .rf_we_i(we5), .rf_waddr_i(waddr5),
    .rf_wdata_i(wdata5), .pc_i(pc5), .dbg_halt_o(halt5), .dbg_resume_o(resume5),
    .dbg_halted_i(halted5), .dbg_req_o(req5), .dbg_gnt_i(gnt5), .dbg_we_o(dwe5),
    .dbg_addr_o(addr5), .dbg_wdata_o(dwd5), .faulty_mask_o(mask5), .fault_o(fault5),
    .fatal_o(fatal5), .recover_cnt_o(rc5)
`ifdef LOCKSTEP_STATS_EN
    , .fault_cnt_o(fc5)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set3(input int k, input logic w, input logic [4:0] a, input logic [31:0] d);
    we3[k] = w;
    waddr3[5*k +: 5] = a;
    wdata3[32*k +: 32] = d;
  endtask

  task automatic reset3();
    rst3 = 1'b1; we3 = '0; halted3 = '0; gnt3 = '0; en3 = 1'b1;
    tick();
    rst3 = 1'b0;
  endtask

  // Plays the cores' side of a recovery that has just been detected (called
  // at the negedge where the halt pulse should be visible) and checks the
  // writes each core receives against the expected register/PC sequence.
  task automatic service3(input string tag, input logic [2:0] exp_mask, input logic exp_we,
                          input logic [4:0] exp_a, input logic [31:0] exp_d,
                          input logic [31:0] exp_pc, input int halt_dly, input int gmax);
    int          nwr[3];
    int          dly[3];
    logic [14:0] wa[3][2];
    logic [31:0] wd[3][2];
    int          halts;
    bit          done;
    int          n, idx;
    halts = 0;
    done  = 1'b0;
    check({tag, " mask"}, 64'(mask3), 64'(exp_mask));
    for (int k = 0; k < 3; k++) begin
      nwr[k] = 0;
      dly[k] = $urandom_range(gmax, 0);
    end
    for (int c = 0; c < 300 && !done; c++) begin
      if (halt3) halts++;
      if (resume3) begin
        done = 1'b1;
      end else begin
        halted3 = (c >= halt_dly) ? 3'b111 : 3'b000;
        for (int k = 0; k < 3; k++) begin
          if (req3[k] && !gnt3[k]) begin
            if (dly[k] == 0) begin
              gnt3[k] = 1'b1;
              if (nwr[k] < 2) begin
                wa[k][nwr[k]] = addr3;
                wd[k][nwr[k]] = dwd3;
              end
              nwr[k]++;
              check({tag, " we during req"}, 64'(dwe3), 64'd1);
            end else begin
              dly[k]--;
            end
          end else if (gnt3[k]) begin
            gnt3[k] = 1'b0;
            dly[k]  = $urandom_range(gmax, 0);
          end
        end
        tick();
      end
    end
    check({tag, " resume seen"}, 64'(done), 64'd1);
    check({tag, " halt pulses"}, 64'(halts), 64'd1);
    check({tag, " fault at resume"}, 64'(fault3), 64'd1);
    for (int k = 0; k < 3; k++) begin
      n = exp_mask[k] ? (exp_we ? 2 : 1) : 0;
      check($sformatf("%s core%0d writes", tag, k), 64'(nwr[k]), 64'(n));
      if (nwr[k] == n && n > 0) begin
        idx = 0;
        if (exp_we) begin
          check($sformatf("%s core%0d reg addr", tag, k), 64'(wa[k][0]), 64'(15'h400 + 15'(exp_a) * 15'd4));
          check($sformatf("%s core%0d reg data", tag, k), 64'(wd[k][0]), 64'(exp_d));
          idx = 1;
        end
        check($sformatf("%s core%0d pc addr", tag, k), 64'(wa[k][idx]), 64'h2000);
        check($sformatf("%s core%0d pc data", tag, k), 64'(wd[k][idx]), 64'(exp_pc));
      end
    end
    halted3 = '0;
    gnt3    = '0;
    tick();
    check({tag, " fault after"}, 64'(fault3), 64'd0);
    check({tag, " idle bus"}, 64'({req3, dwe3, addr3, dwd3}), 64'd0);
  endtask

  typedef struct {
    logic        en;
    logic [2:0]  we;
    logic [14:0] a;
    logic [95:0] d;
    logic        ex_halt;
    logic        ex_fatal;
    logic [2:0]  ex_mask;
  } vec_t;

  vec_t vt[10];

  localparam logic [31:0] D  = 32'h12345678;
  localparam logic [31:0] DX = 32'hDEAD0000;

  // randomized-phase variables
  logic        cw[3];
  logic [4:0]  ca[3];
  logic [31:0] cd[3];
  logic [37:0] key[3];
  int          cnt[3];
  int          maj, exp_rc, nmaj, tmp;
  logic        ren, bw;
  logic [4:0]  ba;
  logic [31:0] bd, rpc;
  logic [2:0]  rmask;
  logic [4:0]  exp_req;

  initial begin
    rst3 = 1'b1; en3 = 1'b0; we3 = '0; waddr3 = '0; wdata3 = '0; pc3 = '0; halted3 = '0; gnt3 = '0;
    rst5 = 1'b1; en5 = 1'b0; we5 = '0; waddr5 = '0; wdata5 = '0; pc5 = '0; halted5 = '0; gnt5 = '0;
    tick(); tick();
    rst3 = 1'b0; rst5 = 1'b0;
    tick();
    check("reset outputs3", 64'({halt3, resume3, req3, dwe3, addr3, mask3, fault3, fatal3}), 64'd0);
    check("reset data3", 64'({dwd3, rc3}), 64'd0);
    check("reset outputs5", 64'({halt5, resume5, req5, dwe5, addr5, mask5, fault5, fatal5, rc5}), 64'd0);

    // ---------------- table-driven detection vectors ----------------
    vt[0] = '{1'b1, 3'b111, {5'd5, 5'd5, 5'd5}, {D, D, D},     1'b0, 1'b0, 3'b000};
    vt[1] = '{1'b1, 3'b000, {5'd3, 5'd2, 5'd1}, {32'd3, 32'd2, 32'd1}, 1'b0, 1'b0, 3'b000};
    vt[2] = '{1'b0, 3'b111, {5'd5, 5'd5, 5'd5}, {D, DX, D},    1'b0, 1'b0, 3'b000};
    vt[3] = '{1'b1, 3'b111, {5'd5, 5'd5, 5'd5}, {D, DX, D},    1'b1, 1'b0, 3'b010};
    vt[4] = '{1'b1, 3'b111, {5'd5, 5'd5, 5'd6}, {D, D, D},     1'b1, 1'b0, 3'b001};
    vt[5] = '{1'b1, 3'b100, {5'd5, 5'd5, 5'd5}, {D, D, D},     1'b1, 1'b0, 3'b100};
    vt[6] = '{1'b1, 3'b011, {5'd5, 5'd5, 5'd5}, {D, 32'd1, 32'd2}, 1'b1, 1'b1, 3'b000};
    vt[7] = '{1'b1, 3'b111, {5'd5, 5'd5, 5'd5}, {32'd3, 32'd2, 32'd1}, 1'b1, 1'b1, 3'b000};
    vt[8] = '{1'b1, 3'b111, {5'd0, 5'd0, 5'd0}, {32'd7, D, D}, 1'b1, 1'b0, 3'b100};
    vt[9] = '{1'b1, 3'b011, {5'd5, 5'd5, 5'd5}, {D, D, D},     1'b1, 1'b0, 3'b100};
    for (int i = 0; i < 10; i++) begin
      reset3();
      en3 = vt[i].en; we3 = vt[i].we; waddr3 = vt[i].a; wdata3 = vt[i].d;
      tick();
      we3 = '0;
      check($sformatf("vec%0d halt", i), 64'(halt3), 64'(vt[i].ex_halt));
      check($sformatf("vec%0d fatal", i), 64'(fatal3), 64'(vt[i].ex_fatal));
      check($sformatf("vec%0d fault", i), 64'(fault3), 64'(vt[i].ex_halt && !vt[i].ex_fatal));
      if (!vt[i].ex_fatal) check($sformatf("vec%0d mask", i), 64'(mask3), 64'(vt[i].ex_mask));
      check($sformatf("vec%0d req", i), 64'(req3), 64'd0);
    end

    // ---------------- core 1 bad data, full recovery ----------------
    reset3();
    set3(0, 1'b1, 5'd5, D); set3(1, 1'b1, 5'd5, DX); set3(2, 1'b1, 5'd5, D);
    pc3 = 32'h80;
    tick();
    we3 = '0; pc3 = '0;
    check("tp2 halt", 64'(halt3), 64'd1);
    service3("tp2", 3'b010, 1'b1, 5'd5, D, 32'h80, 3, 2);
    check("tp2 recover_cnt", 64'(rc3), 64'd1);
    check("tp2 mask held", 64'(mask3), 64'(3'b010));

    // ---------------- only core 2 writes: PC-only recovery ----------------
    set3(2, 1'b1, 5'd9, 32'h55); pc3 = 32'h1234;
    tick();
    we3 = '0;
    check("tp3 halt", 64'(halt3), 64'd1);
    service3("tp3", 3'b100, 1'b0, 5'd0, 32'd0, 32'h1234, 0, 1);
    check("tp3 recover_cnt", 64'(rc3), 64'd2);

    // ---------------- halt timeout ----------------
    reset3();
    set3(0, 1'b1, 5'd1, 32'd1); set3(1, 1'b1, 5'd1, 32'd1); set3(2, 1'b1, 5'd1, 32'd2);
    tick();
    we3 = '0;
    check("to halt", 64'(halt3), 64'd1);
    halted3 = 3'b110;
    tick();
    check("to wait", 64'({fault3, fatal3}), 64'b10);
    for (int i = 0; i < 63; i++) tick();
    check("to not yet fatal", 64'(fatal3), 64'd0);
    tick();
    check("to fatal at 64", 64'(fatal3), 64'd1);
    check("to fatal halt pulse", 64'(halt3), 64'd1);
    tick();
    check("to halt pulse once", 64'(halt3), 64'd0);
    check("to no req", 64'(req3), 64'd0);
    halted3 = '0;

    // ---------------- 5 cores, staggered grants, reset in WR_PC ----------------
    for (int k = 0; k < 5; k++) begin
      we5[k] = 1'b1;
      waddr5[5*k +: 5] = 5'd7;
      wdata5[32*k +: 32] = (k == 1 || k == 3) ? 32'h00000BAD : 32'hCAFE0001;
    end
    en5 = 1'b1; pc5 = 32'h1000;
    tick();
    we5 = '0;
    check("n5 halt", 64'(halt5), 64'd1);
    check("n5 mask", 64'(mask5), 64'(5'b01010));
    halted5 = '1;
    tick();
    check("n5 wait req", 64'(req5), 64'd0);
    tick();
    for (int t = 0; t < 6; t++) begin
      exp_req = (t <= 2) ? 5'b01010 : 5'b01000;
      check($sformatf("n5 reg req t%0d", t), 64'(req5), 64'(exp_req));
      check($sformatf("n5 reg addr t%0d", t), 64'(addr5), 64'h41C);
      check($sformatf("n5 reg data t%0d", t), 64'({dwe5, dwd5}), 64'h1CAFE0001);
      gnt5 = '0;
      if (t == 2) gnt5[1] = 1'b1;
      if (t == 5) gnt5[3] = 1'b1;
      tick();
    end
    gnt5 = '0;
    check("n5 pc req", 64'(req5), 64'(5'b01010));
    check("n5 pc addr", 64'(addr5), 64'h2000);
    check("n5 pc data", 64'(dwd5), 64'h1000);
    rst5 = 1'b1;
    tick();
    check("n5 rst outputs", 64'({halt5, resume5, req5, dwe5, addr5, mask5, fault5, fatal5, rc5}), 64'd0);
    check("n5 rst data", 64'(dwd5), 64'd0);
    rst5 = 1'b0;

    // ---------------- randomized against the reference model ----------------
    reset3();
    exp_rc = 0;
    for (int it = 0; it < 80; it++) begin
      bw = ($urandom_range(3, 0) != 0);
      ba = 5'($urandom);
      bd = $urandom;
      for (int k = 0; k < 3; k++) begin
        cw[k] = bw;
        ca[k] = bw ? ba : 5'($urandom);
        cd[k] = bw ? bd : $urandom;
        if ($urandom_range(2, 0) == 0) begin
          case ($urandom_range(2, 0))
            0: cw[k] = !cw[k];
            1: ca[k] = ca[k] + 5'($urandom_range(31, 1));
            default: cd[k] = cd[k] ^ (32'd1 << $urandom_range(31, 0));
          endcase
        end
      end
      ren = ($urandom_range(7, 0) != 0);
      rpc = $urandom;
      // Model: a tuple is its write-enable, address and data; a disabled
      // write is one tuple regardless of address and data.
      for (int k = 0; k < 3; k++) key[k] = cw[k] ? {1'b1, ca[k], cd[k]} : 38'd0;
      maj = -1;
      for (int i = 0; i < 3; i++) begin
        cnt[i] = 0;
        for (int j = 0; j < 3; j++) if (key[i] == key[j]) cnt[i]++;
        if (maj < 0 && cnt[i] >= 2) maj = i;
      end
      rmask = '0;
      if (maj >= 0) for (int k = 0; k < 3; k++) rmask[k] = (key[k] != key[maj]);
      nmaj = maj;

      en3 = ren; pc3 = rpc;
      for (int k = 0; k < 3; k++) set3(k, cw[k], ca[k], cd[k]);
      tick();
      we3 = '0;
      if (!ren || cnt[0] == 3) begin
        check($sformatf("rnd%0d quiet", it), 64'({halt3, fault3, fatal3}), 64'd0);
      end else if (nmaj >= 0) begin
        check($sformatf("rnd%0d halt", it), 64'({halt3, fatal3}), 64'b10);
        tmp = $urandom_range(10, 0);
        service3($sformatf("rnd%0d", it), rmask, cw[nmaj], ca[nmaj], cd[nmaj], rpc, tmp, 4);
        exp_rc++;
        check($sformatf("rnd%0d recover_cnt", it), 64'(rc3), 64'(exp_rc));
      end else begin
        check($sformatf("rnd%0d fatal", it), 64'({halt3, fatal3}), 64'b11);
        tick();
        check($sformatf("rnd%0d fatal hold", it), 64'({halt3, fatal3, req3}), 64'b0_1_000);
        set3(0, 1'b1, 5'd1, 32'd1); set3(1, 1'b1, 5'd1, 32'd2); set3(2, 1'b1, 5'd1, 32'd2);
        tick();
        we3 = '0;
        check($sformatf("rnd%0d fatal ignores", it), 64'({halt3, fault3, fatal3}), 64'b001);
        reset3();
        exp_rc = 0;
        tick();
        check($sformatf("rnd%0d after rst", it), 64'({fatal3, rc3}), 64'd0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
